// File: rtl/key_pkg.sv
// ============================================================
// key_pkg : shared constants and FSM encoding for key_ctrl
// Rev 1.0
// ============================================================
`default_nettype none

package key_pkg;

    localparam int TIMER_W = 26;
    localparam int DEB_W   = 20;

    localparam logic [DEB_W-1:0]   DEB_MAX_DEF  = 20'd999_999;
    localparam logic [TIMER_W-1:0] LONG_MAX_DEF = 26'd49_999_999;
    localparam logic [TIMER_W-1:0] GAP_MAX_DEF  = 26'd14_999_999;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/key_if.sv
// ============================================================
// key_if : raw key input and decoded key outputs
// Rev 1.0
// ============================================================
`default_nettype none

interface key_if;
    import key_pkg::*;

    logic key_in;
    logic key_state;
    logic single_flag;
    logic double_flag;
    logic long_flag;

    modport master (
        output key_in,
        input  key_state,
        input  single_flag,
        input  double_flag,
        input  long_flag
    );

    modport slave (
        input  key_in,
        output key_state,
        output single_flag,
        output double_flag,
        output long_flag
    );
endinterface

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================
// key_debounce : two-flop synchroniser plus level debouncer
// Rev 1.0
// ============================================================
`default_nettype none

module key_debounce
    import key_pkg::*;
#(
    parameter logic [DEB_W-1:0] DEB_MAX = DEB_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_state
);

    logic             sync1;
    logic             sync2;
    logic [DEB_W-1:0] cnt;

    // Key is active-low, so the sync flops idle at 1 (released).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            cnt       <= '0;
            key_state <= 1'b0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
            if ((!sync2) != key_state) begin
                if (cnt == DEB_MAX) begin
                    key_state <= ~key_state;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/key_ctrl.sv
// ============================================================
// key_ctrl : debounced key decoder for single/double/long press
// Rev 1.0
// ============================================================
`default_nettype none

module key_ctrl
    import key_pkg::*;
#(
    parameter logic [DEB_W-1:0]   DEB_MAX  = DEB_MAX_DEF,
    parameter logic [TIMER_W-1:0] LONG_MAX = LONG_MAX_DEF,
    parameter logic [TIMER_W-1:0] GAP_MAX  = GAP_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    key_if.slave bus
);

    logic               key_state;
    logic               key_state_d;
    logic               press_evt;
    logic               rel_evt;
    state_t             state;
    state_t             state_nxt;
    logic [TIMER_W-1:0] timer;
    logic               single_nxt, double_nxt, long_nxt;
    logic               single_q, double_q, long_q;

    key_debounce #(
        .DEB_MAX (DEB_MAX)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .key_in    (bus.key_in),
        .key_state (key_state)
    );

    assign press_evt = key_state & ~key_state_d;
    assign rel_evt   = ~key_state & key_state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_state_d <= 1'b0;
            state       <= IDLE;
            timer       <= '0;
            single_q    <= 1'b0;
            double_q    <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            key_state_d <= key_state;
            state       <= state_nxt;
            if (state_nxt != state) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + 1'b1;
            end
            single_q <= single_nxt;
            double_q <= double_nxt;
            long_q   <= long_nxt;
        end
    end

    // Events are tested before timeouts so a same-cycle event always wins.
    always_comb begin
        state_nxt  = state;
        single_nxt = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (press_evt) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (rel_evt) begin
                    state_nxt = GAP;
                end else if (timer == LONG_MAX) begin
                    state_nxt = HOLD;
                    long_nxt  = 1'b1;
                end
            end
            GAP: begin
                if (press_evt) begin
                    state_nxt = PRESS2;
                end else if (timer == GAP_MAX) begin
                    state_nxt  = IDLE;
                    single_nxt = 1'b1;
                end
            end
            PRESS2: begin
                if (rel_evt) begin
                    state_nxt  = IDLE;
                    double_nxt = 1'b1;
                end else if (timer == LONG_MAX) begin
                    state_nxt  = HOLD;
                    double_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (rel_evt) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.key_state   = key_state;
    assign bus.single_flag = single_q;
    assign bus.double_flag = double_q;
    assign bus.long_flag   = long_q;

endmodule

`default_nettype wire

// File: tb/tb_key_ctrl.sv
// ============================================================
// tb_key_ctrl : directed + random gestures against a deadline-based model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_key_ctrl;
    import key_pkg::*;

    localparam int DEB  = 4;
    localparam int LONG = 99;
    localparam int GAPT = 29;

    logic clk = 1'b0;
    logic rst = 1'b1;
    key_if bus ();

    key_ctrl #(
        .DEB_MAX  (20'd4),
        .LONG_MAX (26'd99),
        .GAP_MAX  (26'd29)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tick_n = 0;
    int n_single = 0, n_double = 0, n_long = 0, n_rise = 0;
    int last_single = -1, last_double = -1, last_long = -1, last_rise = -1;
    logic prev_ks = 1'b0;

    // Reference: debounced level from run lengths, gestures from absolute deadlines.
    bit m_s1, m_s2, m_lvl, m_lvl_d;
    int m_run;
    int m_presses;
    bit m_gap, m_hold;
    int m_deadline;
    int edge_n = 0;
    bit m_single, m_double, m_long;

    task automatic model_step(input logic k, input logic r);
        bit press, rel, old_lvl;
        edge_n++;
        if (r) begin
            m_s1 = 1; m_s2 = 1; m_lvl = 0; m_lvl_d = 0; m_run = 0;
            m_presses = 0; m_gap = 0; m_hold = 0;
            m_single = 0; m_double = 0; m_long = 0;
        end else begin
            press = m_lvl && !m_lvl_d;
            rel   = !m_lvl && m_lvl_d;
            m_single = 0; m_double = 0; m_long = 0;
            if (m_hold) begin
                if (rel) m_hold = 0;
            end else if (m_presses == 0) begin
                if (press) begin
                    m_presses = 1; m_gap = 0; m_deadline = edge_n + LONG + 1;
                end
            end else if (!m_gap) begin
                if (rel) begin
                    if (m_presses == 1) begin
                        m_gap = 1; m_deadline = edge_n + GAPT + 1;
                    end else begin
                        m_double = 1; m_presses = 0;
                    end
                end else if (edge_n == m_deadline) begin
                    if (m_presses == 1) m_long = 1;
                    else m_double = 1;
                    m_hold = 1; m_presses = 0;
                end
            end else begin
                if (press) begin
                    m_presses = 2; m_gap = 0; m_deadline = edge_n + LONG + 1;
                end else if (edge_n == m_deadline) begin
                    m_single = 1; m_presses = 0; m_gap = 0;
                end
            end
            old_lvl = m_lvl;
            if ((!m_s2) != m_lvl) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_lvl = !m_lvl; m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_lvl_d = old_lvl;
            m_s2 = m_s1;
            m_s1 = k;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d tick=%0d", tag, obs, exp, tick_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(bus.key_in, rst);
        @(negedge clk);
        tick_n++;
        chk("key_state", {31'd0, bus.key_state}, {31'd0, m_lvl});
        chk("single_flag", {31'd0, bus.single_flag}, {31'd0, m_single});
        chk("double_flag", {31'd0, bus.double_flag}, {31'd0, m_double});
        chk("long_flag", {31'd0, bus.long_flag}, {31'd0, m_long});
        if (bus.key_state === 1'b1 && prev_ks === 1'b0) begin n_rise++; last_rise = tick_n; end
        prev_ks = bus.key_state;
        if (bus.single_flag === 1'b1) begin n_single++; last_single = tick_n; end
        if (bus.double_flag === 1'b1) begin n_double++; last_double = tick_n; end
        if (bus.long_flag === 1'b1) begin n_long++; last_long = tick_n; end
    endtask

    task automatic run(input logic k, input int n);
        bus.key_in = k;
        repeat (n) tick();
    endtask

    initial begin
        int base, s0, d0, l0, r0;
        bus.key_in = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_key_state", {31'd0, bus.key_state}, 32'd0);
        chk("rst_flags", {29'd0, bus.single_flag, bus.double_flag, bus.long_flag}, 32'd0);

        // Short glitch must not change the level; a long low is seen after 7 edges.
        r0 = n_rise;
        run(1'b0, 3);
        run(1'b1, 15);
        chk("glitch_rises", n_rise - r0, 0);
        base = tick_n;
        run(1'b0, 20);
        chk("deb_latency", last_rise - base, 7);
        run(1'b1, 60);

        // Single click
        s0 = n_single; d0 = n_double; l0 = n_long;
        run(1'b0, 40);
        base = tick_n;
        run(1'b1, 60);
        chk("single_cnt", n_single - s0, 1);
        chk("single_at", last_single - base, 38);
        chk("single_other", (n_double - d0) + (n_long - l0), 0);

        // Double click
        s0 = n_single; d0 = n_double; l0 = n_long;
        run(1'b0, 40);
        run(1'b1, 10);
        run(1'b0, 40);
        base = tick_n;
        run(1'b1, 60);
        chk("double_cnt", n_double - d0, 1);
        chk("double_at", last_double - base, 8);
        chk("double_other", (n_single - s0) + (n_long - l0), 0);

        // Long press, then release with no further flag
        s0 = n_single; d0 = n_double; l0 = n_long;
        base = tick_n;
        run(1'b0, 300);
        chk("long_cnt", n_long - l0, 1);
        chk("long_at", last_long - base, 108);
        run(1'b1, 60);
        chk("long_after", (n_single - s0) + (n_double - d0) + (n_long - l0), 1);

        // Second press lands exactly on the gap timeout, then reset aborts PRESS2
        s0 = n_single; d0 = n_double; l0 = n_long;
        run(1'b0, 40);
        run(1'b1, 30);
        run(1'b0, 20);
        chk("gap_edge_single", n_single - s0, 0);
        chk("gap_edge_state", {29'd0, dut.state}, {29'd0, PRESS2});
        rst = 1'b1;
        bus.key_in = 1'b1;
        repeat (3) tick();
        chk("mid_rst_outputs", {28'd0, bus.key_state, bus.single_flag, bus.double_flag, bus.long_flag}, 32'd0);
        rst = 1'b0;
        run(1'b1, 80);
        chk("mid_rst_noflag", (n_single - s0) + (n_double - d0) + (n_long - l0), 0);

        // Key held across reset release reads as a fresh press
        rst = 1'b1;
        bus.key_in = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        base = tick_n;
        run(1'b0, 20);
        chk("held_rst_rise", last_rise - base, 7);
        run(1'b1, 60);

        // Random gestures, glitches and gaps against the model
        for (int i = 0; i < 40; i++) begin
            int plen, glen;
            if ($urandom_range(0, 4) == 0) plen = $urandom_range(1, 5);
            else plen = $urandom_range(6, 150);
            glen = $urandom_range(1, 45);
            run(1'b0, plen);
            run(1'b1, glen);
        end
        run(1'b1, 150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/key_ctrl.md
KEY_CTRL -- requirements
Module: key_ctrl

Interface
REQ-001 SHALL provide parameter DEB_MAX, default 20'd999_999, meaning debounce threshold (20 ms at 50 MHz).
REQ-002 SHALL provide parameter LONG_MAX, default 26'd49_999_999, meaning long-press hold time (1 s).
REQ-003 SHALL provide parameter GAP_MAX, default 26'd14_999_999, meaning maximum release gap for a double click (300 ms).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 key_in  input  1  raw asynchronous key, active-low (0 = pressed).
REQ-007 key_state  output  1  debounced level, 1 = pressed.
REQ-008 single_flag  output  1  one-cycle pulse, single click detected.
REQ-009 double_flag  output  1  one-cycle pulse, double click detected.
REQ-010 long_flag  output  1  one-cycle pulse, long press detected.

Function
REQ-011 SHALL synchronise key_in through two flip-flops before any other use.
REQ-012 Debounce SHALL count consecutive cycles where the synchronised input differs from key_state; the counter SHALL clear on any cycle where they agree.
REQ-013 When the debounce count equals DEB_MAX while still differing, key_state SHALL toggle on the next edge and the counter SHALL clear; pulses shorter than DEB_MAX+1 cycles SHALL never change key_state.
REQ-014 SHALL derive press_evt (key_state 0->1) and rel_evt (key_state 1->0) as one-cycle internal strobes.
REQ-015 FSM states: IDLE, PRESS1, GAP, PRESS2, HOLD; one shared 26-bit timer, cleared on every state change, incrementing otherwise, saturating at 2^26-1.
REQ-016 IDLE: press_evt -> PRESS1.
REQ-017 PRESS1: rel_evt with timer < LONG_MAX -> GAP; timer == LONG_MAX while pressed -> HOLD with long_flag.
REQ-018 GAP: press_evt with timer < GAP_MAX -> PRESS2; timer == GAP_MAX -> IDLE with single_flag.
REQ-019 PRESS2: rel_evt -> IDLE with double_flag; timer == LONG_MAX while pressed -> HOLD with double_flag (no long_flag).
REQ-020 HOLD: rel_evt -> IDLE with no flag; further hold SHALL emit nothing.
REQ-021 Timeout and event in the same cycle: the event SHALL win (e.g. press_evt at timer == GAP_MAX in GAP -> PRESS2, no single_flag).
REQ-022 All flags SHALL be registered, asserted exactly one cycle, in the cycle after the qualifying transition edge; at most one flag high per cycle.
REQ-023 Each gesture SHALL yield exactly one flag; a third press after double_flag SHALL start a new gesture from IDLE.

Reset
REQ-024 rst SHALL force state IDLE, timer 0, debounce counter 0, both sync flops 1 (released), key_state 0, all flags 0.
REQ-025 rst asserted mid-gesture SHALL abort it with no flag emitted; a key held across reset release SHALL be seen as a fresh press after DEB_MAX+1 cycles.

Structure
REQ-026 Package key_pkg SHALL hold the FSM state encoding and the default DEB_MAX/LONG_MAX/GAP_MAX constants.
REQ-027 Synchroniser plus debounce (REQ-011..013) SHALL be a sub-module key_debounce outputting key_state; the FSM and timer stay in key_ctrl.

Verification (DEB_MAX=4, LONG_MAX=99, GAP_MAX=29)
REQ-028 Key low 3 cycles then high -> key_state stays 0, no flags; key low 20 cycles -> key_state 1 exactly 7 cycles after the falling edge (2 sync + 5 count).
REQ-029 Single press held 40 cycles, released -> single_flag one cycle, 30 cycles after the GAP entry; no other flag.
REQ-030 Press 40, release 10, press 40, release -> double_flag one cycle after the second rel_evt; no single_flag.
REQ-031 Press held 300 cycles -> long_flag one cycle, 100 cycles after the PRESS1 entry; release -> no further flag.
REQ-032 Second press_evt landing exactly at timer == GAP_MAX -> PRESS2 entered, no single_flag; rst pulsed during PRESS2 -> all outputs 0, no flag after reset release.
